// File: rtl/oled_pkg.sv
// Shared definitions for the OLED panel power-up/command sequencer:
// state encoding, default timing parameters and the panel init table.
package oled_pkg;

  localparam int unsigned DEF_RESET_CYCLES = 1000;
  localparam int unsigned DEF_INIT_LEN     = 8;
  localparam int unsigned DEF_WRITE_CYCLES = 6;

  typedef enum logic [2:0] {
    RES_LOW    = 3'd0,
    RES_HIGH   = 3'd1,
    INIT_ISSUE = 3'd2,
    INIT_WAIT  = 3'd3,
    IDLE       = 3'd4,
    HOST_WAIT  = 3'd5
  } state_t;

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] data;
  } init_entry_t;

  // Panel bring-up table (SSD1306-style). Only the first INIT_LEN entries
  // are replayed; the tail is filled with useful settings and NOPs.
  function automatic init_entry_t init_entry(input logic [3:0] idx);
    init_entry_t e;
    case (idx)
      4'd0:    e = '{cmd: 8'hAE, data: 8'h00};  // display off
      4'd1:    e = '{cmd: 8'hD5, data: 8'h80};  // clock divide
      4'd2:    e = '{cmd: 8'hA8, data: 8'h3F};  // multiplex ratio
      4'd3:    e = '{cmd: 8'hD3, data: 8'h00};  // display offset
      4'd4:    e = '{cmd: 8'h8D, data: 8'h14};  // charge pump on
      4'd5:    e = '{cmd: 8'h20, data: 8'h00};  // horizontal addressing
      4'd6:    e = '{cmd: 8'h81, data: 8'hCF};  // contrast
      4'd7:    e = '{cmd: 8'hAF, data: 8'h00};  // display on
      4'd8:    e = '{cmd: 8'hA1, data: 8'h00};  // segment remap
      4'd9:    e = '{cmd: 8'hC8, data: 8'h00};  // COM scan direction
      4'd10:   e = '{cmd: 8'hDA, data: 8'h12};  // COM pins
      4'd11:   e = '{cmd: 8'hD9, data: 8'hF1};  // precharge
      4'd12:   e = '{cmd: 8'hDB, data: 8'h40};  // VCOMH level
      4'd13:   e = '{cmd: 8'hA4, data: 8'h00};  // follow RAM
      4'd14:   e = '{cmd: 8'hA6, data: 8'h00};  // normal polarity
      default: e = '{cmd: 8'hE3, data: 8'h00};  // NOP
    endcase
    return e;
  endfunction

endpackage

// File: rtl/oled_seq_if.sv
// Host-side request/acknowledge handshake of the OLED sequencer.
interface oled_seq_if;
  logic       host_req;
  logic [7:0] host_cmd;
  logic [7:0] host_data;
  logic       host_ack;

  modport master (output host_req, output host_cmd, output host_data, input host_ack);
  modport slave  (input host_req, input host_cmd, input host_data, output host_ack);
endinterface

// File: rtl/oled_seq.sv
// OLED panel sequencer: drives the panel hardware reset, replays the init
// table through the external byte writer, then forwards host writes.
// Host requests are looked ahead one edge so that ack, wr_start and the
// registered byte outputs all appear together in the first IDLE cycle.
module oled_seq
  import oled_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned INIT_LEN     = DEF_INIT_LEN,
  parameter int unsigned WRITE_CYCLES = DEF_WRITE_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  oled_seq_if.slave   host,
  output logic        ready,
  output logic        busy,
  output logic        oled_res,
  output logic        wr_start,
  output logic [7:0]  wr_command,
  output logic [7:0]  wr_data
);

  localparam logic [15:0] RES_LAST  = 16'(RESET_CYCLES - 1);
  localparam logic [2:0]  WAIT_LAST = 3'(WRITE_CYCLES - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(INIT_LEN - 1);

  state_t      state_r;
  logic [15:0] dly_r;
  logic [2:0]  wait_r;
  logic [3:0]  idx_r;
  logic        ack_r;
  logic        ready_r;
  logic        busy_r;
  logic        res_r;
  logic        start_r;
  logic [7:0]  cmd_r;
  logic [7:0]  data_r;

  logic [3:0]  next_idx_s;
  init_entry_t next_entry_s;

  // Table slot for the next init write: entry 0 after the reset pulse, else the following one
  always_comb begin
    next_idx_s = 4'd0;
    if (state_r == INIT_WAIT) begin
      next_idx_s = idx_r + 4'd1;
    end else begin
      next_idx_s = 4'd0;
    end
    next_entry_s = init_entry(next_idx_s);
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= RES_LOW;
      dly_r   <= 16'd0;
      wait_r  <= 3'd0;
      idx_r   <= 4'd0;
      ack_r   <= 1'b0;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      res_r   <= 1'b0;
      start_r <= 1'b0;
      cmd_r   <= 8'd0;
      data_r  <= 8'd0;
    end else begin
      start_r <= 1'b0;
      ack_r   <= 1'b0;
      case (state_r)
        RES_LOW: begin
          if (dly_r == RES_LAST) begin
            dly_r   <= 16'd0;
            res_r   <= 1'b1;
            state_r <= RES_HIGH;
          end else begin
            dly_r <= dly_r + 16'd1;
          end
        end
        RES_HIGH: begin
          if (dly_r == RES_LAST) begin
            dly_r   <= 16'd0;
            idx_r   <= 4'd0;
            start_r <= 1'b1;
            busy_r  <= 1'b1;
            cmd_r   <= next_entry_s.cmd;
            data_r  <= next_entry_s.data;
            state_r <= INIT_ISSUE;
          end else begin
            dly_r <= dly_r + 16'd1;
          end
        end
        INIT_ISSUE: begin
          wait_r  <= 3'd0;
          state_r <= INIT_WAIT;
        end
        INIT_WAIT: begin
          if (wait_r == WAIT_LAST) begin
            wait_r <= 3'd0;
            if (idx_r == IDX_LAST) begin
              ready_r <= 1'b1;
              busy_r  <= 1'b0;
              state_r <= IDLE;
              if (host.host_req) begin
                ack_r   <= 1'b1;
                start_r <= 1'b1;
                cmd_r   <= host.host_cmd;
                data_r  <= host.host_data;
              end
            end else begin
              idx_r   <= next_idx_s;
              start_r <= 1'b1;
              cmd_r   <= next_entry_s.cmd;
              data_r  <= next_entry_s.data;
              state_r <= INIT_ISSUE;
            end
          end else begin
            wait_r <= wait_r + 3'd1;
          end
        end
        IDLE: begin
          if (ack_r) begin
            // accepted write is now on its way to the byte writer
            wait_r  <= 3'd0;
            busy_r  <= 1'b1;
            state_r <= HOST_WAIT;
          end else if (host.host_req) begin
            ack_r   <= 1'b1;
            start_r <= 1'b1;
            cmd_r   <= host.host_cmd;
            data_r  <= host.host_data;
          end
        end
        HOST_WAIT: begin
          if (wait_r == WAIT_LAST) begin
            wait_r  <= 3'd0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
            if (host.host_req) begin
              ack_r   <= 1'b1;
              start_r <= 1'b1;
              cmd_r   <= host.host_cmd;
              data_r  <= host.host_data;
            end
          end else begin
            wait_r <= wait_r + 3'd1;
          end
        end
        default: begin
          state_r <= RES_LOW;
          dly_r   <= 16'd0;
          wait_r  <= 3'd0;
          idx_r   <= 4'd0;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
          res_r   <= 1'b0;
          cmd_r   <= 8'd0;
          data_r  <= 8'd0;
        end
      endcase
    end
  end

  assign host.host_ack = ack_r;
  assign ready         = ready_r;
  assign busy          = busy_r;
  assign oled_res      = res_r;
  assign wr_start      = start_r;
  assign wr_command    = cmd_r;
  assign wr_data       = data_r;

endmodule

// File: tb/tb_oled_seq.sv
// Self-checking bench for oled_seq: reset pulse timing, init replay,
// host handshake (fixed, back-to-back and randomized gaps), reset mid-write.
module tb_oled_seq;

  localparam int R = 4;
  localparam int L = 8;
  localparam int W = 6;
  localparam int INIT_END = 2 * R + L * (W + 1);

  logic       clk = 1'b0;
  logic       rst;
  logic       ready, busy, oled_res, wr_start;
  logic [7:0] wr_command, wr_data;

  oled_seq_if hif ();

  oled_seq #(.RESET_CYCLES(R), .INIT_LEN(L), .WRITE_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (hif),
    .ready      (ready),
    .busy       (busy),
    .oled_res   (oled_res),
    .wr_start   (wr_start),
    .wr_command (wr_command),
    .wr_data    (wr_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_ack = -1000;

  logic [7:0] tab_cmd  [0:7] = '{8'hAE, 8'hD5, 8'hA8, 8'hD3, 8'h8D, 8'h20, 8'h81, 8'hAF};
  logic [7:0] tab_data [0:7] = '{8'h00, 8'h80, 8'h3F, 8'h00, 8'h14, 8'h00, 8'hCF, 8'h00};

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hif.host_req  = 1'b0;
    hif.host_cmd  = 8'h00;
    hif.host_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // host asks for a write long before the panel is ready
    hif.host_req  = 1'b1;
    hif.host_cmd  = 8'hAF;
    hif.host_data = 8'h01;
    @(posedge clk);
    #1;
    checks++;
    if ({oled_res, wr_start, hif.host_ack, ready, busy, wr_command, wr_data} !== 21'd0)
      $display("FAIL reset_hold: got res=%b start=%b ack=%b ready=%b busy=%b cmd=%h data=%h, want all zero",
               oled_res, wr_start, hif.host_ack, ready, busy, wr_command, wr_data);
    if ({oled_res, wr_start, hif.host_ack, ready, busy, wr_command, wr_data} !== 21'd0) failures++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc = 0;
    last_ack = -1000;
  endtask

  // Walk cycles 0..INIT_END after reset release with AF/01 held by the host
  task automatic test_init(input string tag);
    int starts;
    logic e_res, e_start, e_busy, e_ready, e_ack;
    logic [7:0] e_cmd, e_data;
    starts = 0;
    for (int c = 0; c <= INIT_END; c++) begin
      if (c > 0) step();
      e_res   = (c >= R);
      e_busy  = (c >= 2 * R) && (c < INIT_END);
      e_start = (e_busy && (((c - 2 * R) % (W + 1)) == 0)) || (c == INIT_END);
      e_ready = (c >= INIT_END);
      e_ack   = (c == INIT_END);
      if (c < 2 * R) begin
        e_cmd = 8'h00; e_data = 8'h00;
      end else if (c < INIT_END) begin
        e_cmd = tab_cmd[(c - 2 * R) / (W + 1)]; e_data = tab_data[(c - 2 * R) / (W + 1)];
      end else begin
        e_cmd = 8'hAF; e_data = 8'h01;
      end
      checks++;
      if (oled_res !== e_res) begin
        failures++;
        $display("FAIL %s_oled_res cycle %0d: got %b want %b", tag, c, oled_res, e_res);
      end
      checks++;
      if (wr_start !== e_start) begin
        failures++;
        $display("FAIL %s_wr_start cycle %0d: got %b want %b", tag, c, wr_start, e_start);
      end
      checks++;
      if ({busy, ready, hif.host_ack} !== {e_busy, e_ready, e_ack}) begin
        failures++;
        $display("FAIL %s_status cycle %0d: got busy/ready/ack=%b%b%b want %b%b%b",
                 tag, c, busy, ready, hif.host_ack, e_busy, e_ready, e_ack);
      end
      checks++;
      if ({wr_command, wr_data} !== {e_cmd, e_data}) begin
        failures++;
        $display("FAIL %s_bytes cycle %0d: got %h/%h want %h/%h", tag, c, wr_command, wr_data, e_cmd, e_data);
      end
      if (wr_start === 1'b1) starts++;
    end
    checks++;
    if (starts != L + 1) begin
      failures++;
      $display("FAIL %s_start_count: got %0d want %0d", tag, starts, L + 1);
    end
    last_ack = INIT_END;
  endtask

  // Host writes: ack cycle predicted as max(request+1, previous ack+W+1)
  task automatic test_host(input int n, input bit b2b, input string tag);
    int gap, r, exp_ack;
    bit seen, e_busy;
    logic [7:0] nc, nd;
    for (int k = 0; k < n; k++) begin
      gap = b2b ? 0 : int'($urandom_range(0, 9));
      nc  = 8'($urandom);
      nd  = 8'($urandom);
      r   = cyc + gap;
      if (gap == 0) begin
        hif.host_cmd = nc; hif.host_data = nd; hif.host_req = 1'b1;
      end else begin
        hif.host_req = 1'b0;
      end
      exp_ack = (r + 1 > last_ack + W + 1) ? r + 1 : last_ack + W + 1;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        step();
        if (cyc == r) begin
          hif.host_cmd = nc; hif.host_data = nd; hif.host_req = 1'b1;
        end
        e_busy = (cyc > last_ack) && (cyc <= last_ack + W);
        if (hif.host_ack === 1'b1) begin
          seen = 1'b1;
          checks++;
          if (cyc != exp_ack) begin
            failures++;
            $display("FAIL %s_ack_time req %0d: got cycle %0d want %0d", tag, k, cyc, exp_ack);
          end
          checks++;
          if ({wr_start, busy, ready, wr_command, wr_data} !== {1'b1, 1'b0, 1'b1, nc, nd}) begin
            failures++;
            $display("FAIL %s_ack_cycle req %0d: got start=%b busy=%b ready=%b bytes=%h/%h want 1 0 1 %h/%h",
                     tag, k, wr_start, busy, ready, wr_command, wr_data, nc, nd);
          end
          last_ack = cyc;
        end else begin
          checks++;
          if ({wr_start, busy, ready} !== {1'b0, e_busy, 1'b1}) begin
            failures++;
            $display("FAIL %s_between req %0d cycle %0d: got start/busy/ready=%b%b%b want 0%b1",
                     tag, k, cyc, wr_start, busy, ready, e_busy);
          end
        end
      end
      if (!seen) begin
        checks++;
        failures++;
        $display("FAIL %s_timeout req %0d: no ack by cycle %0d, want cycle %0d", tag, k, cyc, exp_ack);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({oled_res, wr_start, hif.host_ack, ready, busy, wr_command, wr_data} !== 21'd0) begin
      failures++;
      $display("FAIL midreset_immediate: got res=%b start=%b ack=%b ready=%b busy=%b cmd=%h data=%h, want all zero",
               oled_res, wr_start, hif.host_ack, ready, busy, wr_command, wr_data);
    end
    hif.host_req  = 1'b1;
    hif.host_cmd  = 8'hAF;
    hif.host_data = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({oled_res, wr_start, hif.host_ack, ready, busy, wr_command, wr_data} !== 21'd0) begin
      failures++;
      $display("FAIL midreset_hold: got res=%b start=%b ack=%b ready=%b busy=%b cmd=%h data=%h, want all zero",
               oled_res, wr_start, hif.host_ack, ready, busy, wr_command, wr_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc = 0;
    last_ack = -1000;
    test_init("replay");
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_host(5, 1'b1, "b2b");
    test_host(25, 1'b0, "rand");
    test_reset_mid_write();
    test_host(8, 1'b0, "post");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
